sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Parametrised successor to the Y-SRAM bus multiplexer.
- Arbitrates NUM_CLIENTS requesters (control path, write path, future compute units) onto one dual-read / single-write SRAM port. Only one client ever drives the SRAM pins.
- Grants are registered and handed out round-robin. Optional lock and a hold limit provide fairness.
- SRAM-side outputs are registered so the wide data bus meets timing.

Parameters:
NUM_CLIENTS, 2, number of requesting clients (2..8)
ADDR_W, 11, SRAM address width
DATA_W, 256, SRAM write data width
IDLE_ADDR, all ones ({ADDR_W{1'b1}}), address driven when idle, and on read port 1 during writes
MAX_HOLD, 16, cycles an unlocked owner keeps the grant while others wait (>=1)

Ports:
clk  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
in_req  in  NUM_CLIENTS  per-client request, level
in_lock  in  NUM_CLIENTS  per-client lock; owner with lock high is never preempted
in_readAddr1  in  NUM_CLIENTS*ADDR_W  flattened read address 1; client i at [i*ADDR_W +: ADDR_W]
in_readAddr2  in  NUM_CLIENTS*ADDR_W  flattened read address 2
in_we  in  NUM_CLIENTS  per-client write enable
in_writeAddr  in  NUM_CLIENTS*ADDR_W  flattened write address
in_writeData  in  NUM_CLIENTS*DATA_W  flattened write data
op_grant  out  NUM_CLIENTS  one-hot (or zero) registered grant
op_busy  out  1  high while any grant is held
op_yReadAddress1  out  ADDR_W  registered SRAM read address 1
op_yReadAddress2  out  ADDR_W  registered SRAM read address 2
op_yWriteEnable  out  1  registered SRAM write enable
op_yWriteAddress  out  ADDR_W  registered SRAM write address
op_writeData  out  DATA_W  registered SRAM write data

Behaviour:
- Reset (any cycle, including mid-ownership), values at the next edge:
  - op_grant=0, op_busy=0, op_yWriteEnable=0, op_writeData=0.
  - All three address outputs = IDLE_ADDR.
  - hold_cnt=0; round-robin pointer last=NUM_CLIENTS-1, so client 0 has first priority.
- FSM states:
  - IDLE (grant=0): if any in_req, go to OWN with grant = first requester searching from last+1 upward, modulo NUM_CLIENTS. Latency: req sampled at edge t, op_grant high in cycle t+1.
  - OWN (grant[k]=1), exits in priority order:
    - (a) in_req[k]=0: re-arbitrate in the same edge. Go to another requester (searching from k+1) or to IDLE. No dead cycle on handoff.
    - (b) in_lock[k]=0, hold_cnt==MAX_HOLD-1 and another req pending: move grant to next requester from k+1.
    - (c) otherwise stay in OWN, hold_cnt += 1, saturating at MAX_HOLD-1.
  - On every grant change: last=new owner, hold_cnt=0.
- A lock held without a request has no effect. Lock is only evaluated for the current owner.
- Datapath: each edge, the SRAM registers load the fields of the client whose op_grant bit is high in that cycle.
  - Pin latency is 1 cycle from the client driving its fields while granted.
  - With no grant: load the reset/idle values, so op_yWriteEnable=0 in the cycle after a grant drops.
- Write/read collision rule: if the selected in_we=1, op_yReadAddress1 loads IDLE_ADDR and op_yReadAddress2 passes through.
- op_busy = |op_grant, registered together with op_grant.
- A single requester with its req held high keeps the grant indefinitely. The hold limit only applies when others are waiting.
- Invariant: op_grant is always zero or one-hot (assertion in bench).

Test Plan:
1. Reset: hold reset 3 cycles with all reqs high -> op_grant=0, addresses=0x7FF, WE=0, data=0. Release reset -> op_grant=2'b01 one cycle later.
2. Single client: client1 req, readAddr1=0x056, we=0 -> grant=2'b10 at t+1, op_yReadAddress1=0x056 at t+2. Drop req -> WE=0 and addresses=0x7FF two cycles later.
3. Write collision: client0 granted, we=1, writeAddr=0x010, readAddr1=0x020, readAddr2=0x030, data=0xA5..A5 -> pins show WE=1, wrAddr=0x010, rd1=0x7FF, rd2=0x030, data=0xA5..A5.
4. Hold-limit rotation: NUM_CLIENTS=4, MAX_HOLD=4, all reqs high, no locks -> grant sequence 0,1,2,3,0, each held exactly 4 cycles.
5. Lock: same setup with in_lock[0]=1 for 10 cycles -> client0 holds 10+ cycles. Lock drops -> rotates to client1 within 1 cycle, as hold_cnt is saturated.
6. Handoff: owner drops req while client2 requesting -> grant moves to client2 at the same edge with no idle cycle. Assert reset mid-ownership -> grant=0 next cycle.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
// Bundles the client-side request/data lanes and the registered SRAM-side
// pins of the SRAM port arbiter.
//   master : client side (drives in_*, observes op_*)
//   slave  : arbiter side (observes in_*, drives op_*)
// Flattened vectors carry client i at [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W].
interface sram_port_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 256
);
  logic [NUM_CLIENTS-1:0]        in_req;
  logic [NUM_CLIENTS-1:0]        in_lock;
  logic [NUM_CLIENTS*ADDR_W-1:0] in_readAddr1;
  logic [NUM_CLIENTS*ADDR_W-1:0] in_readAddr2;
  logic [NUM_CLIENTS-1:0]        in_we;
  logic [NUM_CLIENTS*ADDR_W-1:0] in_writeAddr;
  logic [NUM_CLIENTS*DATA_W-1:0] in_writeData;

  logic [NUM_CLIENTS-1:0]        op_grant;
  logic                          op_busy;
  logic [ADDR_W-1:0]             op_yReadAddress1;
  logic [ADDR_W-1:0]             op_yReadAddress2;
  logic                          op_yWriteEnable;
  logic [ADDR_W-1:0]             op_yWriteAddress;
  logic [DATA_W-1:0]             op_writeData;

  modport master (
    output in_req, in_lock, in_readAddr1, in_readAddr2, in_we, in_writeAddr, in_writeData,
    input  op_grant, op_busy, op_yReadAddress1, op_yReadAddress2, op_yWriteEnable,
           op_yWriteAddress, op_writeData
  );

  modport slave (
    input  in_req, in_lock, in_readAddr1, in_readAddr2, in_we, in_writeAddr, in_writeData,
    output op_grant, op_busy, op_yReadAddress1, op_yReadAddress2, op_yWriteEnable,
           op_yWriteAddress, op_writeData
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Round-robin arbiter placing NUM_CLIENTS requesters onto one dual-read /
// single-write SRAM port. Grant and all SRAM pins are registered.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - sram_port_arbiter_if.slave (client lanes in, SRAM pins out)
//
// state | meaning
// IDLE  | no grant held, SRAM pins at idle values
// OWN   | grantQ[k] held by one client, hold counter running
module sram_port_arbiter #(
  parameter int                NUM_CLIENTS = 2,
  parameter int                ADDR_W      = 11,
  parameter int                DATA_W      = 256,
  parameter logic [ADDR_W-1:0] IDLE_ADDR   = {ADDR_W{1'b1}},
  parameter int                MAX_HOLD    = 16
) (
  input logic                clk,
  input logic                reset,
  sram_port_arbiter_if.slave bus
);

  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                 stateQ, stateD;
  logic [NUM_CLIENTS-1:0] grantQ, grantD;
  logic                   busyQ;
  logic [CW-1:0]          lastQ, lastD;
  logic [HW-1:0]          holdQ, holdD;

  logic [ADDR_W-1:0]      rd1Q, rd1D, rd2Q, rd2D, waQ, waD;
  logic                   weQ, weD;
  logic [DATA_W-1:0]      dataQ, dataD;

  logic [CW-1:0]          ownerIdx, searchBase, candIdx, pos;
  logic                   candValid, othersPending, take;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      grantQ <= '0;
      busyQ  <= 1'b0;
      lastQ  <= CW'(NUM_CLIENTS - 1);
      holdQ  <= '0;
      rd1Q   <= IDLE_ADDR;
      rd2Q   <= IDLE_ADDR;
      waQ    <= IDLE_ADDR;
      weQ    <= 1'b0;
      dataQ  <= '0;
    end else begin
      stateQ <= stateD;
      grantQ <= grantD;
      busyQ  <= |grantD;
      lastQ  <= lastD;
      holdQ  <= holdD;
      rd1Q   <= rd1D;
      rd2Q   <= rd2D;
      waQ    <= waD;
      weQ    <= weD;
      dataQ  <= dataD;
    end
  end

  // Next-state logic
  always_comb begin
    ownerIdx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (grantQ[i]) ownerIdx = CW'(i);

    // Round-robin search starts just past the owner (or the last owner when idle).
    // Walk from farthest to nearest so the nearest requester wins.
    searchBase = (stateQ == OWN) ? ownerIdx : lastQ;
    candValid  = 1'b0;
    candIdx    = '0;
    pos        = '0;
    for (int off = NUM_CLIENTS; off >= 1; off--) begin
      pos = CW'((int'(searchBase) + off) % NUM_CLIENTS);
      if (bus.in_req[pos]) begin
        candValid = 1'b1;
        candIdx   = pos;
      end
    end

    othersPending = |(bus.in_req & ~grantQ);

    stateD = stateQ;
    grantD = grantQ;
    lastD  = lastQ;
    holdD  = holdQ;
    take   = 1'b0;

    case (stateQ)
      IDLE: begin
        if (candValid) take = 1'b1;
      end
      OWN: begin
        if (!bus.in_req[ownerIdx]) begin
          // Owner released: hand off in the same edge, or fall idle.
          if (candValid) begin
            take = 1'b1;
          end else begin
            stateD = IDLE;
            grantD = '0;
            holdD  = '0;
          end
        end else if (!bus.in_lock[ownerIdx] && holdQ == HOLD_TOP && othersPending) begin
          take = 1'b1;
        end else if (holdQ != HOLD_TOP) begin
          holdD = holdQ + HW'(1);
        end
      end
      default: begin
        stateD = IDLE;
        grantD = '0;
        holdD  = '0;
      end
    endcase

    if (take) begin
      stateD = OWN;
      grantD = NUM_CLIENTS'(1) << candIdx;
      lastD  = candIdx;
      holdD  = '0;
    end
  end

  // SRAM pin selection from the client granted in the current cycle
  always_comb begin
    rd1D  = IDLE_ADDR;
    rd2D  = IDLE_ADDR;
    waD   = IDLE_ADDR;
    weD   = 1'b0;
    dataD = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grantQ[i]) begin
        weD   = bus.in_we[i];
        waD   = bus.in_writeAddr[i*ADDR_W +: ADDR_W];
        // Read port 1 shares the array with the write; park it during writes.
        rd1D  = bus.in_we[i] ? IDLE_ADDR : bus.in_readAddr1[i*ADDR_W +: ADDR_W];
        rd2D  = bus.in_readAddr2[i*ADDR_W +: ADDR_W];
        dataD = bus.in_writeData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Outputs
  always_comb begin
    bus.op_grant         = grantQ;
    bus.op_busy          = busyQ;
    bus.op_yReadAddress1 = rd1Q;
    bus.op_yReadAddress2 = rd2Q;
    bus.op_yWriteEnable  = weQ;
    bus.op_yWriteAddress = waQ;
    bus.op_writeData     = dataQ;
  end

endmodule
